// File: rtl/lsu.sv
// lsu -- RV32I load/store unit sitting at the execute->memory boundary.
//
// Accepts one memory op at a time from the core. It runs that op as a single
// word-wide transaction on the data bus. Stores have their data replicated
// into the addressed byte lanes. Loads have the addressed byte or half
// extracted and then sign- or zero-extended. An access is rejected without
// touching the bus if it is misaligned or uses an illegal funct3. A bus that
// never acks is abandoned after TIMEOUT cycles.
//
// Ports:
//   i_clk, i_reset          clock (rising edge), async active-high reset
//   i_req_valid/o_req_ready core handshake; ready only while idle
//   i_req_we/funct3/addr/wdata  op kind, RV32I funct3, effective address, rs2
//   o_mem_req/we/addr/wdata/bmask  bus request, held until ack or timeout
//   i_mem_ack/i_mem_rdata   bus completion and read word
//   o_rsp_valid/rdata/err   one-cycle completion pulse, load result, error code
//                           (00 ok, 01 misaligned/illegal, 10 bus timeout)

module lsu #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_ERR,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic              req_bad;
    logic [1:0]        offset;
    logic [31:0]       store_data;
    logic [3:0]        lane_mask;
    logic [31:0]       load_shifted;
    logic [31:0]       load_data;

    // Decide at accept time whether the incoming op may go to the bus at all.
    // funct3[1:0] encodes the access size (0=B, 1=H, 2=W); loads additionally
    // allow the unsigned B/H forms with funct3[2] set.
    always_comb begin
        req_bad = 1'b0;
        if (i_req_we) begin
            if (i_req_funct3[2] || (i_req_funct3[1:0] == 2'b11)) begin
                req_bad = 1'b1;
            end
        end else begin
            if ((i_req_funct3 == 3'b011) || (i_req_funct3 == 3'b110) ||
                (i_req_funct3 == 3'b111)) begin
                req_bad = 1'b1;
            end
        end
        if ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) begin
            req_bad = 1'b1;
        end
        if ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
    end

    // Next-state logic. The timeout counter counts BUS cycles that end without
    // an ack; an ack always takes priority over expiry on the final cycle.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    we_d      = i_req_we;
                    funct3_d  = i_req_funct3;
                    addr_d    = i_req_addr;
                    wdata_d   = i_req_wdata;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = req_bad ? S_ERR : S_BUS;
                end
            end
            S_BUS: begin
                if (i_mem_ack) begin
                    rdata_d = i_mem_rdata;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ERR:   state_d = S_IDLE;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Lane steering for both directions, derived from the registered op so
    // the bus sees stable values for every BUS cycle.
    always_comb begin
        offset = addr_q[1:0];
        case (funct3_q[1:0])
            2'b00: begin
                store_data = {4{wdata_q[7:0]}};
                lane_mask  = 4'b0001 << offset;
            end
            2'b01: begin
                store_data = {2{wdata_q[15:0]}};
                lane_mask  = 4'b0011 << offset;
            end
            default: begin
                store_data = wdata_q;
                lane_mask  = 4'b1111;
            end
        endcase
        load_shifted = rdata_q >> {offset, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b100:  load_data = {24'h0, load_shifted[7:0]};
            3'b001:  load_data = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b101:  load_data = {16'h0, load_shifted[15:0]};
            default: load_data = load_shifted;
        endcase
    end

    // Outputs are purely state-decoded so an async reset drops the bus
    // request immediately. Everything idles at zero outside its active state.
    always_comb begin
        o_req_ready = (state_q == S_IDLE);
        o_mem_req   = (state_q == S_BUS);
        o_mem_we    = o_mem_req & we_q;
        o_mem_addr  = o_mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
        o_mem_wdata = o_mem_req ? store_data : 32'h0;
        o_mem_bmask = o_mem_req ? lane_mask : 4'b0000;
        o_rsp_valid = (state_q == S_RESP) || (state_q == S_ERR);
        o_rsp_err   = 2'b00;
        o_rsp_rdata = 32'h0;
        if (state_q == S_ERR) begin
            o_rsp_err = 2'b01;
        end else if (state_q == S_RESP) begin
            if (timeout_q) begin
                o_rsp_err = 2'b10;
            end else if (!we_q) begin
                o_rsp_rdata = load_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- self-checking bench for lsu. Directed cases cover the documented
// corner cases. A run of random ops is then checked against a behavioural
// model computed from the RV32I access rules.

module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int checkCount;
    int passCount;

    lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_bmask  (mem_bmask),
        .i_mem_ack    (mem_ack),
        .i_mem_rdata  (mem_rdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Issues one op and plays the bus side. ackDelay is the BUS cycle index
    // (0 = first) on which ack is returned; 16 or more means never.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int ackDelay, input logic [31:0] rdata);
        int unsigned size;
        int unsigned off;
        bit          legal;
        logic [31:0] expMask;
        logic [31:0] expWdata;
        logic [31:0] expRdata;
        logic [31:0] w;
        logic [31:0] part;
        int          last;

        // Reference model: size from funct3, natural alignment, lane replication.
        size  = 1 << (f3 & 3);
        off   = addr % 4;
        legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
        if (size == 8 || (addr % size) != 0) legal = 0;
        expMask  = ((32'd1 << size) - 1) << off;
        expWdata = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
                   (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
        w = rdata >> (8 * off);
        if (size == 1) begin
            part     = w & 32'hFF;
            expRdata = (f3 == 0 && part >= 32'h80) ? part - 32'h100 : part;
        end else if (size == 2) begin
            part     = w & 32'hFFFF;
            expRdata = (f3 == 1 && part >= 32'h8000) ? part - 32'h1_0000 : part;
        end else begin
            expRdata = w;
        end

        @(negedge clk);
        checkOutput("ready_before", req_ready, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        if (!legal) begin
            @(negedge clk);
            checkOutput("err_valid", rsp_valid, 1);
            checkOutput("err_code", rsp_err, 2'b01);
            checkOutput("err_rdata", rsp_rdata, 0);
            checkOutput("err_noreq", mem_req, 0);
        end else begin
            last = (ackDelay < 16) ? ackDelay : 15;
            for (int c = 0; c <= last; c++) begin
                @(negedge clk);
                checkOutput("bus_req", mem_req, 1);
                checkOutput("bus_norsp", rsp_valid, 0);
                checkOutput("bus_addr", mem_addr, addr & 32'hFFFF_FFFC);
                checkOutput("bus_we", mem_we, we);
                checkOutput("bus_bmask", mem_bmask, expMask);
                if (we) checkOutput("bus_wdata", mem_wdata, expWdata);
                mem_ack   = (c == ackDelay);
                mem_rdata = (c == ackDelay) ? rdata : $urandom;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            checkOutput("rsp_valid", rsp_valid, 1);
            checkOutput("rsp_noreq", mem_req, 0);
            checkOutput("rsp_err", rsp_err, (ackDelay < 16) ? 2'b00 : 2'b10);
            checkOutput("rsp_rdata", rsp_rdata,
                        (ackDelay < 16 && !we) ? expRdata : 32'h0);
        end
        @(negedge clk);
        checkOutput("rsp_pulse", rsp_valid, 0);
        checkOutput("ready_after", req_ready, 1);
    endtask

    initial begin
        logic [2:0] f3;
        int         d;
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;

        #12;
        checkOutput("rst_ready", req_ready, 1);
        checkOutput("rst_memreq", mem_req, 0);
        checkOutput("rst_rspvalid", rsp_valid, 0);
        checkOutput("rst_bmask", mem_bmask, 0);
        checkOutput("rst_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Documented corner cases.
        applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_1234);
        applyStimulus(1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 2, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
        applyStimulus(1'b1, 3'b011, 32'h100, 32'h1234, 0, 32'h0);
        applyStimulus(1'b0, 3'b101, 32'h002, 32'h0, 99, 32'h0);
        applyStimulus(1'b0, 3'b101, 32'h002, 32'h0, 15, 32'hABCD_1234);
        applyStimulus(1'b1, 3'b000, 32'h301, 32'h0000_00A5, 1, 32'h0);

        // Reset while the bus is waiting abandons the op.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h400;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_req", mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_req", mem_req, 0);
        checkOutput("mid_rst_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("mid_no_rsp", rsp_valid, 0);
            checkOutput("mid_ready", req_ready, 1);
        end

        // Random ops.
        for (int i = 0; i < 80; i++) begin
            f3 = 3'($urandom_range(0, 7));
            d  = $urandom_range(0, 9);
            if (d == 8) d = 15;
            if (d == 9) d = 40;
            applyStimulus(1'($urandom_range(0, 1)), f3, $urandom, $urandom, d, $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
